key_search_scheduler: RTL and testbench

- Parametrised multi-core secret-key search controller for the RC4 decoder.
- Hands out candidate keys to NUM_CORES decrypt/check cores in ascending order and collects their per-key pass/fail results.
- Stops the search on the first success, or reports exhaustion once every key below KEY_LIMIT has been tried.
- Sits between the top level (switches and LEDs) and the array of RC4 cores.

---
 rtl/key_search_scheduler.sv | 124 ++++++++++++
 tb/tb_key_search_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_search_scheduler.sv
// Multi-core key search controller for the RC4 decoder: issues candidate keys
// in ascending order to free cores, collects pass/fail results, stops on first hit.
module key_search_scheduler #(
  parameter int KEY_W     = 24,
  parameter int NUM_CORES = 4,
  parameter int KEY_START = 0,
  parameter int KEY_LIMIT = 2**22,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_success,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*KEY_W-1:0] core_key,
  output logic                       core_abort,
  output logic                       busy,
  output logic                       found,
  output logic                       exhausted,
  output logic [KEY_W-1:0]           found_key,
  output logic [IDX_W-1:0]           found_core,
  output logic [9:0]                 LEDR
);

  // One extra bit so a limit of 2**KEY_W is reachable without wrapping.
  localparam logic [KEY_W:0] LIMIT = (KEY_W+1)'(KEY_LIMIT);
  localparam logic [KEY_W:0] START = (KEY_W+1)'(KEY_START);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_EXHAUSTED} state_t;

  state_t               state, state_d;
  logic [KEY_W:0]       next_key, next_key_d;
  logic [NUM_CORES-1:0] core_busy, core_busy_d, start_d;
  logic [NUM_CORES-1:0] done_vld, succ_vld;
  logic [IDX_W-1:0]     succ_idx, free_idx;
  logic                 succ_any, free_any, dispatch;

  // Top seven key bits for the LEDs; narrow keys are left-aligned and zero padded.
  function automatic logic [6:0] led_key(input logic [KEY_W-1:0] k);
    logic [KEY_W+6:0] ext;
    ext = {k, 7'b0};
    return ext[KEY_W+6 -: 7];
  endfunction

  // Pulses from idle cores are spurious and never qualify.
  always_comb begin
    done_vld = core_done & core_busy;
    succ_vld = done_vld & core_success;
    succ_any = |succ_vld;
    free_any = ~&core_busy;
    succ_idx = '0;
    free_idx = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (succ_vld[i])   succ_idx = IDX_W'(i);
      if (!core_busy[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d     = state;
    next_key_d  = next_key;
    core_busy_d = core_busy;
    start_d     = '0;
    dispatch    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (succ_any) begin
          state_d     = S_FOUND;
          core_busy_d = '0;
        end else begin
          // Free slots come from the registered busy bits, so a core that
          // finishes this edge is only eligible on the next one.
          dispatch    = enable && (next_key < LIMIT) && free_any;
          core_busy_d = core_busy & ~done_vld;
          if (dispatch) begin
            core_busy_d[free_idx] = 1'b1;
            start_d[free_idx]     = 1'b1;
            next_key_d            = next_key + (KEY_W+1)'(1);
          end
          if (next_key == LIMIT && core_busy == '0) state_d = S_EXHAUSTED;
        end
      end
      default: core_busy_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      next_key   <= START;
      core_busy  <= '0;
      core_start <= '0;
      core_key   <= '0;
      core_abort <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_key  <= '0;
      found_core <= '0;
      LEDR       <= '0;
    end else begin
      state      <= state_d;
      next_key   <= next_key_d;
      core_busy  <= core_busy_d;
      core_start <= start_d;
      if (dispatch) core_key[free_idx*KEY_W +: KEY_W] <= next_key[KEY_W-1:0];
      if (state == S_RUN && succ_any) begin
        found_key  <= core_key[succ_idx*KEY_W +: KEY_W];
        found_core <= succ_idx;
      end
      busy       <= (state_d == S_RUN);
      found      <= (state_d == S_FOUND);
      core_abort <= (state_d == S_FOUND);
      exhausted  <= (state_d == S_EXHAUSTED);
      LEDR       <= {led_key(next_key_d[KEY_W-1:0]), state_d == S_EXHAUSTED,
                     state_d == S_FOUND, state_d == S_RUN};
    end
  end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Bench for key_search_scheduler: emulated cores with per-key latency/result
// tables, checked every cycle against a key-level model of the search.
module tb_key_search_scheduler;
  localparam int KW = 4;
  localparam int NC = 4;
  localparam int KL = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic [NC-1:0]  core_done = '0;
  logic [NC-1:0]  core_success = '0;
  logic [NC-1:0]  core_start;
  logic [NC*KW-1:0] core_key;
  logic           core_abort, busy, found, exhausted;
  logic [KW-1:0]  found_key;
  logic [1:0]     found_core;
  logic [9:0]     LEDR;

  key_search_scheduler #(.KEY_W(KW), .NUM_CORES(NC), .KEY_START(0), .KEY_LIMIT(KL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .core_done(core_done),
    .core_success(core_success), .core_start(core_start), .core_key(core_key),
    .core_abort(core_abort), .busy(busy), .found(found), .exhausted(exhausted),
    .found_key(found_key), .found_core(found_core), .LEDR(LEDR));

  always #5 clk = ~clk;

  int asserts = 0;
  int fails = 0;

  // Search model: which cores hold a key, which key is next, terminal flags.
  bit          m_run, m_found, m_exh;
  int          m_next, m_fkey, m_fcore;
  bit [NC-1:0] m_hold;
  int          m_key[NC];
  // Emulated cores and per-key behaviour tables.
  bit          live[NC];
  int          cnt[NC];
  int          ckey[NC];
  int          lat_of_key[KL];
  bit          win_key[KL];
  int          issued[KL];
  bit          spur_en;
  int          spur_rate;

  task automatic model_clear();
    m_run = 0; m_found = 0; m_exh = 0; m_next = 0; m_fkey = 0; m_fcore = 0; m_hold = '0;
    for (int i = 0; i < NC; i++) begin live[i] = 0; cnt[i] = 0; ckey[i] = -1; m_key[i] = 0; end
    for (int k = 0; k < KL; k++) begin issued[k] = 0; win_key[k] = 0; lat_of_key[k] = 3; end
    spur_en = 0; spur_rate = 0;
    core_done = '0; core_success = '0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0; enable = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  // Predict one edge from the model, advance the clock, compare, then drive the cores.
  task automatic step();
    int win, disp;
    bit anyhold;
    logic [NC-1:0] exp_start;
    logic [KW-1:0] k;
    win = -1; disp = -1; exp_start = '0;
    if (m_run) begin
      for (int i = NC-1; i >= 0; i--)
        if (core_done[i] && core_success[i] && m_hold[i]) win = i;
      if (win >= 0) begin
        m_found = 1; m_run = 0; m_fkey = m_key[win]; m_fcore = win; m_hold = '0;
      end else begin
        anyhold = |m_hold;
        if (enable && m_next < KL)
          for (int i = NC-1; i >= 0; i--) if (!m_hold[i]) disp = i;
        if (!anyhold && m_next == KL) begin m_exh = 1; m_run = 0; end
        m_hold = m_hold & ~core_done;
        if (disp >= 0) begin
          m_hold[disp] = 1; m_key[disp] = m_next; m_next++; exp_start[disp] = 1'b1;
        end
      end
    end else if (!m_found && !m_exh && enable) begin
      m_run = 1;
    end

    @(posedge clk); #1;
    asserts++;
    if (core_start !== exp_start) begin fails++; $display("FAIL core_start: got %b want %b", core_start, exp_start); end
    if (disp >= 0) begin
      asserts++;
      if (core_key[disp*KW +: KW] !== KW'(m_key[disp])) begin
        fails++; $display("FAIL core_key[%0d]: got %0d want %0d", disp, core_key[disp*KW +: KW], m_key[disp]);
      end
    end
    asserts++;
    if (busy !== m_run) begin fails++; $display("FAIL busy: got %b want %b", busy, m_run); end
    asserts++;
    if (found !== m_found) begin fails++; $display("FAIL found: got %b want %b", found, m_found); end
    asserts++;
    if (exhausted !== m_exh) begin fails++; $display("FAIL exhausted: got %b want %b", exhausted, m_exh); end
    asserts++;
    if (core_abort !== m_found) begin fails++; $display("FAIL core_abort: got %b want %b", core_abort, m_found); end
    asserts++;
    if (LEDR[2:0] !== {m_exh, m_found, m_run}) begin
      fails++; $display("FAIL ledr_status: got %b want %b", LEDR[2:0], {m_exh, m_found, m_run});
    end
    if (m_found) begin
      asserts++;
      if (found_key !== KW'(m_fkey)) begin fails++; $display("FAIL found_key: got %0d want %0d", found_key, m_fkey); end
      asserts++;
      if (found_core !== 2'(m_fcore)) begin fails++; $display("FAIL found_core: got %0d want %0d", found_core, m_fcore); end
    end

    for (int i = 0; i < NC; i++) begin
      if (core_start[i]) begin
        k = core_key[i*KW +: KW];
        issued[k]++; live[i] = 1; ckey[i] = k; cnt[i] = lat_of_key[k];
      end
    end
    core_done = '0; core_success = '0;
    for (int i = 0; i < NC; i++) begin
      if (core_abort) live[i] = 0;
      if (live[i]) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          core_done[i] = 1'b1; core_success[i] = win_key[ckey[i]]; live[i] = 0;
        end
      end
    end
    if (spur_en && ($urandom_range(0, 99) < spur_rate)) begin
      int j;
      j = $urandom_range(0, NC-1);
      if (!m_hold[j] && !core_done[j]) begin
        core_done[j] = 1'b1; core_success[j] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run(input int budget, input string name);
    int n;
    n = 0;
    while (!(m_found || m_exh) && n < budget) begin step(); n++; end
    asserts++;
    if (!(m_found || m_exh)) begin fails++; $display("FAIL %s_timeout: got running want terminal", name); end
  endtask

  task automatic test_reset();
    #3;
    asserts++;
    if ({core_start, core_key, core_abort, busy, found, exhausted, found_key, found_core, LEDR} !== '0) begin
      fails++; $display("FAIL reset_outputs: got start=%b key=%h led=%b want all zero", core_start, core_key, LEDR);
    end
    do_reset();
    step();
    asserts++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_exhaust();
    do_reset();
    spur_en = 1; spur_rate = 30;
    enable = 1'b1;
    run(300, "exhaust");
    for (int k = 0; k < KL; k++) begin
      asserts++;
      if (issued[k] != 1) begin fails++; $display("FAIL issue_once[%0d]: got %0d want 1", k, issued[k]); end
    end
    asserts++;
    if (LEDR[2] !== 1'b1 || exhausted !== 1'b1) begin
      fails++; $display("FAIL exhaust_flags: got led2=%b exh=%b want 1 1", LEDR[2], exhausted);
    end
    asserts++;
    if (found !== 1'b0) begin fails++; $display("FAIL exhaust_found: got %b want 0", found); end
    repeat (6) step();
  endtask

  task automatic test_found();
    int holder;
    do_reset();
    for (int k = 0; k < KL; k++) lat_of_key[k] = $urandom_range(1, 4);
    win_key[9] = 1;
    enable = 1'b1;
    run(200, "found");
    holder = -1;
    for (int i = 0; i < NC; i++) if (ckey[i] == 9) holder = i;
    spur_en = 1; spur_rate = 100;
    repeat (10) step();
    asserts++;
    if (found_key !== 4'd9) begin fails++; $display("FAIL found_key9: got %0d want 9", found_key); end
    asserts++;
    if (int'(found_core) != holder) begin fails++; $display("FAIL found_core9: got %0d want %0d", found_core, holder); end
    asserts++;
    if (core_abort !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL found_abort: got abort=%b busy=%b want 1 0", core_abort, busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    lat_of_key[1] = 4; lat_of_key[3] = 2;
    win_key[1] = 1; win_key[3] = 1;
    enable = 1'b1;
    run(50, "simul");
    asserts++;
    if (found_core !== 2'd1) begin fails++; $display("FAIL simul_core: got %0d want 1", found_core); end
    asserts++;
    if (found_key !== 4'd1) begin fails++; $display("FAIL simul_key: got %0d want 1", found_key); end
  endtask

  task automatic test_pause();
    int n;
    logic [NC-1:0] seen;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (m_next < 5 && n < 20) begin step(); n++; end
    enable = 1'b0;
    seen = '0;
    step();
    asserts++;
    if (busy !== 1'b1) begin fails++; $display("FAIL pause_busy: got %b want 1", busy); end
    repeat (9) begin step(); seen |= core_start; end
    asserts++;
    if (seen !== '0 || busy !== 1'b1) begin
      fails++; $display("FAIL pause_hold: got start=%b busy=%b want 0000 1", seen, busy);
    end
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (core_start == '0 && n < 5);
    asserts++;
    if (core_start !== 4'b0001 || core_key[KW-1:0] !== 4'd5) begin
      fails++; $display("FAIL resume_key: got start=%b key0=%0d want 0001 5", core_start, core_key[KW-1:0]);
    end
    run(200, "pause");
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    enable = 1'b1;
    n = 0;
    while (m_next < 8 && n < 30) begin step(); n++; end
    #2 reset = 1'b0;
    #1;
    asserts++;
    if ({core_start, core_key, core_abort, busy, found, exhausted, found_key, found_core, LEDR} !== '0) begin
      fails++; $display("FAIL async_reset: got start=%b key=%h busy=%b led=%b want all zero", core_start, core_key, busy, LEDR);
    end
    model_clear();
    enable = 1'b0;
    @(negedge clk) reset = 1'b1;
    enable = 1'b1;
    n = 0;
    do begin step(); n++; end while (core_start == '0 && n < 5);
    asserts++;
    if (core_start !== 4'b0001 || core_key[KW-1:0] !== 4'd0) begin
      fails++; $display("FAIL restart_key: got start=%b key0=%0d want 0001 0", core_start, core_key[KW-1:0]);
    end
    run(200, "restart");
  endtask

  task automatic test_random();
    int t, n;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int k = 0; k < KL; k++) lat_of_key[k] = $urandom_range(1, 6);
      t = $urandom_range(0, KL);
      if (t < KL) win_key[t] = 1;
      spur_en = 1; spur_rate = 25;
      n = 0;
      while (!(m_found || m_exh) && n < 600) begin
        enable = ($urandom_range(0, 3) != 0);
        step(); n++;
      end
      asserts++;
      if (found !== (t < KL) || exhausted !== (t == KL)) begin
        fails++; $display("FAIL random_outcome[%0d]: got found=%b exh=%b target=%0d", it, found, exhausted, t);
      end
      if (t < KL) begin
        asserts++;
        if (int'(found_key) != t) begin fails++; $display("FAIL random_key[%0d]: got %0d want %0d", it, found_key, t); end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_exhaust();
    test_found();
    test_simultaneous();
    test_pause();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
